cafeteira_programavel: RTL and testbench

Parametrised successor to the single-shot coffee-machine FSM: the same nine-step brewing sequence, extended with programmable per-step dwell time, multi-cup batches, a water-level sensor with fill timeout, an error state and an abort. It sits under the machine's front-panel logic. `state` keeps the 4-bit encoding used across the design, so existing sequence monitors still apply.

---
 rtl/cafeteira_programavel_pkg.sv | 35 +++
 rtl/cafeteira_programavel_step_timer.sv | 36 +++
 rtl/cafeteira_programavel.sv | 154 +++++++++++++++
 tb/tb_cafeteira_programavel.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cafeteira_programavel_pkg.sv
// maquina_pkg: shared definitions for the programmable coffee machine.
// Holds the 4-bit state codes, the state enum built on them, and the
// default parameter values. Sequence monitors and benches import it too.
package maquina_pkg;

  localparam int STATE_W          = 4;
  localparam int DEF_STEP_CYCLES  = 4;
  localparam int DEF_FILL_TIMEOUT = 16;
  localparam int DEF_CUPS_W       = 3;

  localparam logic [STATE_W-1:0] ST_IDLE              = 4'd1;
  localparam logic [STATE_W-1:0] ST_LIGAR_MAQUINA     = 4'd2;
  localparam logic [STATE_W-1:0] ST_VERIFICAR_AGUA    = 4'd3;
  localparam logic [STATE_W-1:0] ST_ENCHER_RESERV     = 4'd4;
  localparam logic [STATE_W-1:0] ST_MOER_CAFE         = 4'd5;
  localparam logic [STATE_W-1:0] ST_COLOCAR_NO_FILTRO = 4'd6;
  localparam logic [STATE_W-1:0] ST_PASSAR_AGITADOR   = 4'd7;
  localparam logic [STATE_W-1:0] ST_TAMPEAR           = 4'd8;
  localparam logic [STATE_W-1:0] ST_REALIZAR_EXTRACAO = 4'd9;
  localparam logic [STATE_W-1:0] ST_ERRO              = 4'd10;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = ST_IDLE,
    S_LIGAR    = ST_LIGAR_MAQUINA,
    S_VERIF    = ST_VERIFICAR_AGUA,
    S_ENCHER   = ST_ENCHER_RESERV,
    S_MOER     = ST_MOER_CAFE,
    S_FILTRO   = ST_COLOCAR_NO_FILTRO,
    S_AGITADOR = ST_PASSAR_AGITADOR,
    S_TAMPEAR  = ST_TAMPEAR,
    S_EXTRACAO = ST_REALIZAR_EXTRACAO,
    S_ERRO     = ST_ERRO
  } state_t;

endpackage

// File: rtl/cafeteira_programavel_step_timer.sv
// step_timer: cycle counter shared by the dwell and fill-timeout compares.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   limit    : terminal value; tc is high while the count equals it
//   tc       : terminal-count flag, decoded from the registered count
module step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Counter register: clear on state change, otherwise count while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == limit);

endmodule

// File: rtl/cafeteira_programavel.sv
// cafeteira_programavel: multi-cup brewing sequencer with programmable
// per-step dwell, water-level check with fill timeout, error and abort.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   start     : begin a batch (IDLE only, cups must be non-zero)
//   cups      : cups requested, latched on an accepted start
//   agua_ok   : reservoir level sufficient
//   abort     : cancel the batch / leave ERRO
//   state     : current 4-bit state code
//   busy      : state != IDLE
//   done      : one-cycle pulse on normal batch completion
//   erro      : state == ERRO
//   cups_done : cups completed in the current or last batch
module cafeteira_programavel
  import maquina_pkg::*;
#(
  parameter int STEP_CYCLES  = DEF_STEP_CYCLES,
  parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT,
  parameter int CUPS_W       = DEF_CUPS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CUPS_W-1:0]   cups,
  input  logic                agua_ok,
  input  logic                abort,
  output logic [STATE_W-1:0]  state,
  output logic                busy,
  output logic                done,
  output logic                erro,
  output logic [CUPS_W-1:0]   cups_done
);

  localparam int MAX_CYC = (STEP_CYCLES > FILL_TIMEOUT) ? STEP_CYCLES : FILL_TIMEOUT;
  localparam int TW      = $clog2(MAX_CYC + 1);
  // tc fires in the last cycle of a dwell, so the compare value is N-1.
  localparam logic [TW-1:0] STEP_LIM = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] FILL_LIM = TW'(FILL_TIMEOUT - 1);

  state_t              state_r;
  state_t              state_next_s;
  logic [CUPS_W-1:0]   target_r;
  logic [CUPS_W-1:0]   cups_done_r;
  logic [CUPS_W-1:0]   cups_inc_s;
  logic                done_r;
  logic                tc_s;
  logic                timer_en_s;
  logic                timer_clr_s;
  logic [TW-1:0]       limit_s;
  logic                accept_s;
  logic                finish_s;

  assign accept_s    = (state_r == S_IDLE) && start && (cups != {CUPS_W{1'b0}});
  // Abort wins over the extraction finishing on the same edge.
  assign finish_s    = (state_r == S_EXTRACAO) && tc_s && !abort;
  assign timer_clr_s = (state_next_s != state_r);
  assign limit_s     = (state_r == S_ENCHER) ? FILL_LIM : STEP_LIM;

  // Saturating increment of the completed-cup counter.
  always_comb begin
    cups_inc_s = cups_done_r;
    if (cups_done_r == {CUPS_W{1'b1}}) begin
      cups_inc_s = cups_done_r;
    end else begin
      cups_inc_s = cups_done_r + CUPS_W'(1);
    end
  end

  // Timer runs only in states that dwell or wait for water.
  always_comb begin
    timer_en_s = 1'b0;
    case (state_r)
      S_ENCHER, S_MOER, S_FILTRO, S_AGITADOR, S_TAMPEAR, S_EXTRACAO: timer_en_s = 1'b1;
      default: timer_en_s = 1'b0;
    endcase
  end

  // Next-state logic; abort outside IDLE overrides every normal transition.
  always_comb begin
    state_next_s = state_r;
    if (abort && (state_r != S_IDLE)) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:     state_next_s = accept_s ? S_LIGAR : S_IDLE;
        S_LIGAR:    state_next_s = S_VERIF;
        S_VERIF:    state_next_s = agua_ok ? S_MOER : S_ENCHER;
        S_ENCHER: begin
          if (agua_ok) begin
            state_next_s = S_VERIF;
          end else if (tc_s) begin
            state_next_s = S_ERRO;
          end else begin
            state_next_s = S_ENCHER;
          end
        end
        S_MOER:     state_next_s = tc_s ? S_FILTRO   : S_MOER;
        S_FILTRO:   state_next_s = tc_s ? S_AGITADOR : S_FILTRO;
        S_AGITADOR: state_next_s = tc_s ? S_TAMPEAR  : S_AGITADOR;
        S_TAMPEAR:  state_next_s = tc_s ? S_EXTRACAO : S_TAMPEAR;
        S_EXTRACAO: begin
          if (!tc_s) begin
            state_next_s = S_EXTRACAO;
          end else if (cups_inc_s < target_r) begin
            state_next_s = S_VERIF;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_ERRO:     state_next_s = S_ERRO;
        default:    state_next_s = S_IDLE;
      endcase
    end
  end

  // FSM state, batch registers and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      target_r    <= {CUPS_W{1'b0}};
      cups_done_r <= {CUPS_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= finish_s && !(cups_inc_s < target_r);
      if (accept_s) begin
        target_r    <= cups;
        cups_done_r <= {CUPS_W{1'b0}};
      end else if (finish_s) begin
        target_r    <= target_r;
        cups_done_r <= cups_inc_s;
      end else begin
        target_r    <= target_r;
        cups_done_r <= cups_done_r;
      end
    end
  end

  step_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr_s),
    .en    (timer_en_s),
    .limit (limit_s),
    .tc    (tc_s)
  );

  assign state     = state_r;
  assign busy      = (state_r != S_IDLE);
  assign erro      = (state_r == S_ERRO);
  assign done      = done_r;
  assign cups_done = cups_done_r;

endmodule

// File: tb/tb_cafeteira_programavel.sv
// Directed self-checking bench for cafeteira_programavel (STEP_CYCLES=2,
// FILL_TIMEOUT=16, CUPS_W=3). Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point.
module tb_cafeteira_programavel;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] cups;
  logic       agua_ok;
  logic       abort;
  logic [3:0] state;
  logic       busy;
  logic       done;
  logic       erro;
  logic [2:0] cups_done;

  int checks     = 0;
  int failures   = 0;
  int done_seen  = 0;
  int d0         = 0;

  cafeteira_programavel #(
    .STEP_CYCLES  (2),
    .FILL_TIMEOUT (16),
    .CUPS_W       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cups      (cups),
    .agua_ok   (agua_ok),
    .abort     (abort),
    .state     (state),
    .busy      (busy),
    .done      (done),
    .erro      (erro),
    .cups_done (cups_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic step_state(input string tag, input logic [3:0] exp);
    step();
    chk(tag, {28'd0, state}, {28'd0, exp});
  endtask

  // One cup of processing with STEP_CYCLES=2: 5,5,6,6,7,7,8,8,9,9.
  task automatic cup_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step_state(tag, 4'(5 + i / 2));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cups = 3'd0; agua_ok = 1'b0; abort = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_state", {28'd0, state}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    chk("rst_cups_done", {29'd0, cups_done}, 32'd0);

    // One cup, water present: 12 cycles after acceptance back in IDLE.
    agua_ok = 1'b1; cups = 3'd1; start = 1'b1; d0 = done_seen;
    step_state("t1_ligar", 4'd2);
    start = 1'b0; cups = 3'd0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step_state("t1_verif", 4'd3);
    cup_steps("t1_proc", 10);
    step_state("t1_idle", 4'd1);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_cups_done", {29'd0, cups_done}, 32'd1);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    step();
    chk("t1_done_low", {31'd0, done}, 32'd0);
    chk("t1_done_once", done_seen - d0, 32'd1);

    // Low water for three ENCHER cycles, then refilled.
    agua_ok = 1'b0; cups = 3'd1; start = 1'b1;
    step_state("t2_ligar", 4'd2);
    start = 1'b0;
    step_state("t2_verif", 4'd3);
    step_state("t2_encher", 4'd4);
    step_state("t2_encher", 4'd4);
    step_state("t2_encher", 4'd4);
    agua_ok = 1'b1;
    step_state("t2_reverif", 4'd3);
    cup_steps("t2_proc", 10);
    step_state("t2_idle", 4'd1);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_erro", {31'd0, erro}, 32'd0);

    // Fill timeout: 16 ENCHER cycles then ERRO; start ignored; abort clears.
    agua_ok = 1'b0; cups = 3'd1; start = 1'b1;
    step_state("t3_ligar", 4'd2);
    start = 1'b0;
    step_state("t3_verif", 4'd3);
    step_state("t3_encher_first", 4'd4);
    for (int i = 0; i < 15; i++) step_state("t3_encher", 4'd4);
    step_state("t3_erro_state", 4'd10);
    chk("t3_erro", {31'd0, erro}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; cups = 3'd1;
    step_state("t3_start_ignored", 4'd10);
    start = 1'b0; abort = 1'b1;
    step_state("t3_abort_idle", 4'd1);
    abort = 1'b0;
    chk("t3_erro_clr", {31'd0, erro}, 32'd0);
    chk("t3_no_done", {31'd0, done}, 32'd0);

    // Three cups: LIGAR once, cups_done steps 0,1,2 then 3, single done.
    agua_ok = 1'b1; cups = 3'd3; start = 1'b1; d0 = done_seen;
    step_state("t4_ligar", 4'd2);
    start = 1'b0;
    chk("t4_cups_clr", {29'd0, cups_done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step_state("t4_verif", 4'd3);
      chk("t4_cups_done", {29'd0, cups_done}, 32'(c));
      cup_steps("t4_proc", 10);
    end
    step_state("t4_idle", 4'd1);
    chk("t4_cups_final", {29'd0, cups_done}, 32'd3);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_done_once", done_seen - d0, 32'd1);

    // Abort in PASSAR_AGITADOR of cup 2 of 3, then start with cups=0.
    cups = 3'd3; start = 1'b1; d0 = done_seen;
    step_state("t5_ligar", 4'd2);
    start = 1'b0;
    step_state("t5_verif", 4'd3);
    cup_steps("t5_cup1", 10);
    step_state("t5_verif2", 4'd3);
    chk("t5_cups_mid", {29'd0, cups_done}, 32'd1);
    cup_steps("t5_cup2", 5);
    abort = 1'b1;
    step_state("t5_abort", 4'd1);
    abort = 1'b0;
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_cups_kept", {29'd0, cups_done}, 32'd1);
    start = 1'b1; cups = 3'd0;
    step_state("t5_zero_cups", 4'd1);
    step_state("t5_zero_cups2", 4'd1);
    start = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_cups_still", {29'd0, cups_done}, 32'd1);
    chk("t5_no_done", done_seen - d0, 32'd0);

    // Reset during TAMPEAR of cup 2, then a normal two-cup batch.
    cups = 3'd2; start = 1'b1;
    step_state("t6_ligar", 4'd2);
    start = 1'b0;
    step_state("t6_verif", 4'd3);
    cup_steps("t6_cup1", 10);
    step_state("t6_verif2", 4'd3);
    cup_steps("t6_cup2", 8);
    chk("t6_cups_pre", {29'd0, cups_done}, 32'd1);
    rst = 1'b1;
    step_state("t6_rst_state", 4'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_cups", {29'd0, cups_done}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0; cups = 3'd2; start = 1'b1; d0 = done_seen;
    step_state("t6b_ligar", 4'd2);
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step_state("t6b_verif", 4'd3);
      cup_steps("t6b_proc", 10);
    end
    step_state("t6b_idle", 4'd1);
    chk("t6b_done", {31'd0, done}, 32'd1);
    chk("t6b_cups", {29'd0, cups_done}, 32'd2);
    chk("t6b_done_once", done_seen - d0, 32'd1);

    // abort together with start in IDLE: start wins; abort in LIGAR cancels.
    abort = 1'b1; start = 1'b1; cups = 3'd1;
    step_state("t7_accept", 4'd2);
    start = 1'b0;
    step_state("t7_abort", 4'd1);
    abort = 1'b0;

    // abort on the final edge of REALIZAR_EXTRACAO: no increment, no done.
    agua_ok = 1'b1; cups = 3'd1; start = 1'b1; d0 = done_seen;
    step_state("t8_ligar", 4'd2);
    start = 1'b0;
    step_state("t8_verif", 4'd3);
    cup_steps("t8_proc", 9);
    abort = 1'b1;
    step_state("t8_abort", 4'd1);
    abort = 1'b0;
    chk("t8_done", {31'd0, done}, 32'd0);
    chk("t8_cups", {29'd0, cups_done}, 32'd0);
    step();
    chk("t8_no_done", done_seen - d0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
